// File: rtl/fibonacci_checker.sv
// fibonacci_checker: receive-side checker for the Fibonacci generator stream.
// Hunts for the 0,1 seed, then tracks 0,1,1,2,3,5,... and follows the
// generator's wrap back to 0. Flags mismatches and wraps with one-cycle pulses
// and saturating counters. All outputs are registered.
//
// Build option:
//   FIBONACCI_CHECKER_ZERO_HOLD_EN - when defined, a repeated 0 while waiting
//   for the 1 of the seed is accepted silently (generator holding 0 in reset).
//   When undefined, the repeated 0 counts as a mismatch and becomes the new seed.
module fibonacci_checker #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_value,
    input  logic                 clr,
    output logic                 locked,
    output logic                 err_pulse,
    output logic                 wrap_pulse,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [CNT_WIDTH-1:0] wrap_count,
    output logic [WIDTH-1:0]     expected
);

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_SEEN0 = 2'd1,
        ST_TRACK = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     p2_q, p2_d;
    logic [WIDTH-1:0]     p1_q, p1_d;
    logic                 locked_q, locked_d;
    logic                 err_q, err_d;
    logic                 wrap_q, wrap_d;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_WIDTH-1:0] wrap_cnt_q, wrap_cnt_d;
    logic [WIDTH-1:0]     expected_q, expected_d;

    logic                 wrap_due_now;
    logic [WIDTH-1:0]     next_term_now;

    // Counter increment that sticks at all-ones instead of rolling over.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_WIDTH'(1);
    endfunction

    // A wrap is due when the next sum reaches the top bit of the word. The
    // carry out cannot be set while both terms came from an accepted stream
    // (each is below half range); it is folded in so a stray pair still wraps.
    function automatic logic wrap_of(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[WIDTH] | s[WIDTH-1];
    endfunction

    // Next term the stream must deliver; 0 when the generator is due to wrap.
    function automatic logic [WIDTH-1:0] expect_of(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[WIDTH] | s[WIDTH-1]) begin
            return '0;
        end
        return s[WIDTH-1:0];
    endfunction

    assign wrap_due_now  = wrap_of(p1_q, p2_q);
    assign next_term_now = expect_of(p1_q, p2_q);

    // Next-state logic: sequence FSM, term pair, event flags, counters and
    // the registered view of the value required on the next sample.
    always_comb begin
        state_d = state_q;
        p2_d    = p2_q;
        p1_d    = p1_q;
        err_d   = 1'b0;
        wrap_d  = 1'b0;

        if (in_valid) begin
            case (state_q)
                ST_HUNT: begin
                    // Anything but the seed start is ignored while hunting.
                    if (in_value == '0) begin
                        state_d = ST_SEEN0;
                    end
                end

                ST_SEEN0: begin
                    if (in_value == WIDTH'(1)) begin
                        p2_d    = '0;
                        p1_d    = WIDTH'(1);
                        state_d = ST_TRACK;
                    end else if (in_value == '0) begin
`ifdef FIBONACCI_CHECKER_ZERO_HOLD_EN
                        // Generator holding 0: keep waiting for the 1.
                        state_d = ST_SEEN0;
`else
                        // Repeated 0 is an error but also a fresh seed.
                        err_d   = 1'b1;
                        state_d = ST_SEEN0;
`endif
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_HUNT;
                    end
                end

                ST_TRACK: begin
                    if (wrap_due_now) begin
                        if (in_value == '0) begin
                            wrap_d  = 1'b1;
                            state_d = ST_SEEN0;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_HUNT;
                        end
                    end else if (in_value == next_term_now) begin
                        p2_d = p1_q;
                        p1_d = in_value;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_HUNT;
                    end
                end

                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end

        // Clear has priority over a coincident event; the pulse still fires.
        if (clr) begin
            err_cnt_d = '0;
        end else if (err_d) begin
            err_cnt_d = sat_inc(err_cnt_q);
        end else begin
            err_cnt_d = err_cnt_q;
        end

        if (clr) begin
            wrap_cnt_d = '0;
        end else if (wrap_d) begin
            wrap_cnt_d = sat_inc(wrap_cnt_q);
        end else begin
            wrap_cnt_d = wrap_cnt_q;
        end

        locked_d = (state_d == ST_TRACK);
        if (state_d == ST_TRACK) begin
            expected_d = expect_of(p1_d, p2_d);
        end else begin
            expected_d = '0;
        end
    end

    // State and output registers; reset forces the idle hunting condition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_HUNT;
            p2_q       <= '0;
            p1_q       <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            wrap_q     <= 1'b0;
            err_cnt_q  <= '0;
            wrap_cnt_q <= '0;
            expected_q <= '0;
        end else begin
            state_q    <= state_d;
            p2_q       <= p2_d;
            p1_q       <= p1_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            wrap_q     <= wrap_d;
            err_cnt_q  <= err_cnt_d;
            wrap_cnt_q <= wrap_cnt_d;
            expected_q <= expected_d;
        end
    end

    assign locked     = locked_q;
    assign err_pulse  = err_q;
    assign wrap_pulse = wrap_q;
    assign err_count  = err_cnt_q;
    assign wrap_count = wrap_cnt_q;
    assign expected   = expected_q;

endmodule

// File: tb/tb_fibonacci_checker.sv
// tb_fibonacci_checker: directed scenarios plus randomized stream for
// fibonacci_checker (WIDTH=8, CNT_WIDTH=4), checked against a reference model.
module tb_fibonacci_checker;

    localparam int W    = 8;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int HALF = 1 << (W - 1);

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic [W-1:0]  in_value;
    logic          clr;
    logic          locked;
    logic          err_pulse;
    logic          wrap_pulse;
    logic [CW-1:0] err_count;
    logic [CW-1:0] wrap_count;
    logic [W-1:0]  expected;

    int n_checks;
    int n_errors;

    // Reference model: mode 0 = looking for 0, 1 = have the 0, 2 = following.
    int mode;
    int older;
    int newer;
    int m_err_cnt;
    int m_wrap_cnt;
    bit m_err;
    bit m_wrap;

    fibonacci_checker #(
        .WIDTH     (W),
        .CNT_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_value   (in_value),
        .clr        (clr),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .wrap_pulse (wrap_pulse),
        .err_count  (err_count),
        .wrap_count (wrap_count),
        .expected   (expected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_expected();
        int s;
        if (mode != 2) return 0;
        s = older + newer;
        if (s >= HALF) return 0;
        return s;
    endfunction

    task automatic model_reset();
        mode       = 0;
        older      = 0;
        newer      = 0;
        m_err_cnt  = 0;
        m_wrap_cnt = 0;
        m_err      = 0;
        m_wrap     = 0;
    endtask

    task automatic model_update(input bit v, input int val, input bit c);
        int s;
        m_err  = 0;
        m_wrap = 0;
        if (v) begin
            if (mode == 0) begin
                if (val == 0) mode = 1;
            end else if (mode == 1) begin
                if (val == 1) begin
                    older = 0;
                    newer = 1;
                    mode  = 2;
                end else if (val == 0) begin
`ifndef FIBONACCI_CHECKER_ZERO_HOLD_EN
                    m_err = 1;
`endif
                end else begin
                    m_err = 1;
                    mode  = 0;
                end
            end else begin
                s = older + newer;
                if (s >= HALF) begin
                    if (val == 0) begin
                        m_wrap = 1;
                        mode   = 1;
                    end else begin
                        m_err = 1;
                        mode  = 0;
                    end
                end else if (val == s) begin
                    older = newer;
                    newer = s;
                end else begin
                    m_err = 1;
                    mode  = 0;
                end
            end
        end
        if (c) m_err_cnt = 0;
        else if (m_err && m_err_cnt < CMAX) m_err_cnt++;
        if (c) m_wrap_cnt = 0;
        else if (m_wrap && m_wrap_cnt < CMAX) m_wrap_cnt++;
    endtask

    task automatic compare_all();
        check("locked",     32'(locked),     32'(mode == 2));
        check("err_pulse",  32'(err_pulse),  32'(m_err));
        check("wrap_pulse", 32'(wrap_pulse), 32'(m_wrap));
        check("err_count",  32'(err_count),  32'(m_err_cnt));
        check("wrap_count", 32'(wrap_count), 32'(m_wrap_cnt));
        check("expected",   32'(expected),   32'(model_expected()));
    endtask

    // One clock cycle: drive inputs, take the edge, update model, compare.
    task automatic step(input bit v, input int val, input bit c);
        in_valid = v;
        in_value = W'(val);
        clr      = c;
        @(posedge clk);
        model_update(v, val, c);
        #1;
        compare_all();
    endtask

    initial begin
        int fib_a;
        int fib_b;
        int r;
        int val;
        bit v;
        bit c;

        n_checks = 0;
        n_errors = 0;
        model_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_value = '0;
        clr      = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_locked",   32'(locked),     32'd0);
        check("rst_errp",     32'(err_pulse),  32'd0);
        check("rst_wrapp",    32'(wrap_pulse), 32'd0);
        check("rst_errcnt",   32'(err_count),  32'd0);
        check("rst_wrapcnt",  32'(wrap_count), 32'd0);
        check("rst_expected", 32'(expected),   32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;

        // Lock
        step(1, 0, 0);
        check("lock_not_yet", 32'(locked), 32'd0);
        step(1, 1, 0);
        check("lock_after_seed", 32'(locked), 32'd1);
        step(1, 1, 0);
        step(1, 2, 0);
        step(1, 3, 0);
        step(1, 5, 0);
        check("exp_after_5", 32'(expected), 32'd8);
        check("lock_no_err", 32'(err_count), 32'd0);

        // Wrap
        fib_a = 3;
        fib_b = 5;
        while (fib_b != 89) begin
            r     = fib_a + fib_b;
            fib_a = fib_b;
            fib_b = r;
            step(1, fib_b, 0);
        end
        check("exp_wrap_due", 32'(expected), 32'd0);
        check("still_locked", 32'(locked), 32'd1);
        step(1, 0, 0);
        check("wrap_pulse_hi", 32'(wrap_pulse), 32'd1);
        check("wrap_cnt_1",    32'(wrap_count), 32'd1);
        check("wrap_unlock",   32'(locked),     32'd0);
        step(0, 77, 0);
        check("wrap_pulse_lo", 32'(wrap_pulse), 32'd0);
        step(1, 1, 0);
        check("relock_wrap", 32'(locked), 32'd1);

        // Mismatch
        step(1, 1, 0);
        step(1, 2, 0);
        step(1, 3, 0);
        step(1, 9, 0);
        check("mm_pulse",  32'(err_pulse), 32'd1);
        check("mm_cnt",    32'(err_count), 32'd1);
        check("mm_unlock", 32'(locked),    32'd0);
        step(1, 0, 0);
        check("mm_pulse_once", 32'(err_pulse), 32'd0);
        step(1, 1, 0);
        check("mm_relock", 32'(locked), 32'd1);

        // Gaps with junk values
        step(0, 200, 0);
        step(1, 1, 0);
        step(0, 33, 0);
        step(0, 4, 0);
        step(1, 2, 0);
        step(0, 255, 0);
        step(1, 3, 0);
        check("gap_exp",  32'(expected),  32'd5);
        check("gap_errs", 32'(err_count), 32'd1);

        // Clear coinciding with a mismatch
        step(1, 77, 1);
        check("clr_pulse", 32'(err_pulse), 32'd1);
        check("clr_cnt",   32'(err_count), 32'd0);

        // Zero hold from hunting
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 0);
`ifdef FIBONACCI_CHECKER_ZERO_HOLD_EN
        check("zh_errs", 32'(err_count), 32'd0);
`else
        check("zh_errs", 32'(err_count), 32'd2);
`endif
        check("zh_lock", 32'(locked), 32'd1);

        // Back-to-back mismatches and counter saturation
        step(1, 200, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0);
            step(1, 7, 0);
        end
        check("err_sat", 32'(err_count), 32'(CMAX));
        step(1, 0, 0);
        step(1, 5, 0);
        check("err_sat_hold", 32'(err_count), 32'(CMAX));

        // Asynchronous reset mid-track
        step(1, 0, 1);
        step(1, 1, 0);
        step(1, 1, 0);
        step(1, 2, 0);
        step(1, 3, 0);
        check("pre_rst_lock", 32'(locked), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_locked",   32'(locked),     32'd0);
        check("arst_errcnt",   32'(err_count),  32'd0);
        check("arst_wrapcnt",  32'(wrap_count), 32'd0);
        check("arst_expected", 32'(expected),   32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        step(1, 5, 0);
        check("post_rst_hunt", 32'(locked),    32'd0);
        check("post_rst_errs", 32'(err_count), 32'd0);

        // Randomized stream biased toward following the sequence
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            v = (r < 85);
            r = int'($urandom_range(0, 99));
            if (r < 70) begin
                if (mode == 2) val = model_expected();
                else if (mode == 1) val = ($urandom_range(0, 9) < 8) ? 1 : 0;
                else val = 0;
            end else if (r < 85) begin
                val = int'($urandom_range(0, 1));
            end else begin
                val = int'($urandom_range(0, 255));
            end
            c = ($urandom_range(0, 199) == 0);
            step(v, val, c);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
